memory_port_arbiter: RTL and testbench

- Shares one single-ported memory subsystem between the instruction-fetch requester (i_mem_*) and the data requester (d_mem_*).
- Sits between memory_interface and a single-port memory, for cores or configurations where instruction and data traffic cannot use separate BRAM ports.
- Each requester port has a one-entry request register. Arbitration is round-robin or fixed-priority, with one outstanding memory transaction and a response watchdog.

---
 rtl/memory_port_arbiter_pkg.sv | 26 ++
 rtl/memory_port_arbiter_if.sv | 40 ++++
 rtl/memory_port_arbiter_rr_arbiter_2.sv | 42 ++++
 rtl/memory_port_arbiter.sv | 259 +++++++++++++++++++++++++
 tb/tb_memory_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter:
// FSM state encoding, requester port IDs and operation encoding.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10
    } state_e;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    // The requester that is not p; used for round-robin alternation.
    function automatic port_e other_port(input port_e p);
        return (p == PORT_INSTR) ? PORT_DATA : PORT_INSTR;
    endfunction

endpackage

// File: rtl/memory_port_arbiter_if.sv
// Command/response bus between the arbiter (master) and the shared
// single-port memory (slave).
interface memory_port_arbiter_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    logic                    mem_read;
    logic                    mem_write;
    logic [NUM_BYTES-1:0]    mem_byte_en;
    logic [ADDRESS_BITS-1:0] mem_address_in;
    logic [DATA_WIDTH-1:0]   mem_data_in;
    logic                    mem_ready;
    logic                    mem_valid;
    logic [DATA_WIDTH-1:0]   mem_data_out;

    modport master (
        output mem_read,
        output mem_write,
        output mem_byte_en,
        output mem_address_in,
        output mem_data_in,
        input  mem_ready,
        input  mem_valid,
        input  mem_data_out
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_byte_en,
        input  mem_address_in,
        input  mem_data_in,
        output mem_ready,
        output mem_valid,
        output mem_data_out
    );

endinterface

// File: rtl/memory_port_arbiter_rr_arbiter_2.sv
// Two-requester grant logic. Round-robin on ties (the port that did not
// win last time), or data-always-wins when FIXED_PRIORITY is set.
module rr_arbiter_2
    import memory_arbiter_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0
)(
    input  logic  clock,
    input  logic  reset,
    input  logic  grant_en,
    input  logic  req_instr,
    input  logic  req_data,
    output logic  grant_valid,
    output port_e grant_port
);

    port_e last_grant_q;
    port_e last_grant_d;

    // Pick a winner and remember it whenever a grant is actually taken.
    always_comb begin
        grant_valid = grant_en && (req_instr || req_data);
        if (req_instr && req_data) begin
            grant_port = (FIXED_PRIORITY != 0) ? PORT_DATA : other_port(last_grant_q);
        end else if (req_data) begin
            grant_port = PORT_DATA;
        end else begin
            grant_port = PORT_INSTR;
        end
        last_grant_d = grant_valid ? grant_port : last_grant_q;
    end

    // Last-grant history; starts at DATA so the first tie goes to instruction.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_q <= PORT_DATA;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch and data
// requesters. Each requester has a one-entry request register; one memory
// transaction is outstanding at a time, guarded by a response watchdog.
module memory_port_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_BITS   = 32,
    parameter int FIXED_PRIORITY = 0,
    parameter int TIMEOUT_CYCLES = 1023
)(
    input  logic                      clock,
    input  logic                      reset,

    input  logic                      i_mem_read,
    input  logic [ADDRESS_BITS-1:0]   i_mem_address_in,
    output logic                      i_mem_ready,
    output logic                      i_mem_valid,
    output logic [DATA_WIDTH-1:0]     i_mem_data_out,
    output logic [ADDRESS_BITS-1:0]   i_mem_address_out,

    input  logic                      d_mem_read,
    input  logic                      d_mem_write,
    input  logic [DATA_WIDTH/8-1:0]   d_mem_byte_en,
    input  logic [ADDRESS_BITS-1:0]   d_mem_address_in,
    input  logic [DATA_WIDTH-1:0]     d_mem_data_in,
    output logic                      d_mem_ready,
    output logic                      d_mem_valid,
    output logic [DATA_WIDTH-1:0]     d_mem_data_out,
    output logic [ADDRESS_BITS-1:0]   d_mem_address_out,

    memory_port_arbiter_if.master     mem,

    output logic                      timeout_error
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef struct packed {
        op_e                     op;
        logic [NUM_BYTES-1:0]    byte_en;
        logic [ADDRESS_BITS-1:0] addr;
        logic [DATA_WIDTH-1:0]   data;
    } req_t;

    state_e                  state_q,      state_d;
    port_e                   grant_q,      grant_d;
    req_t                    i_req_q,      i_req_d;
    req_t                    d_req_q,      d_req_d;
    logic                    i_pending_q,  i_pending_d;
    logic                    d_pending_q,  d_pending_d;
    logic                    i_ready_q,    i_ready_d;
    logic                    d_ready_q,    d_ready_d;
    logic                    i_valid_q,    i_valid_d;
    logic                    d_valid_q,    d_valid_d;
    logic [DATA_WIDTH-1:0]   i_data_q,     i_data_d;
    logic [DATA_WIDTH-1:0]   d_data_q,     d_data_d;
    logic [ADDRESS_BITS-1:0] i_addr_out_q, i_addr_out_d;
    logic [ADDRESS_BITS-1:0] d_addr_out_q, d_addr_out_d;
    logic                    mem_read_q,   mem_read_d;
    logic                    mem_write_q,  mem_write_d;
    logic [NUM_BYTES-1:0]    mem_be_q,     mem_be_d;
    logic [ADDRESS_BITS-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q,  mem_wdata_d;
    logic [CNT_W-1:0]        wait_cnt_q,   wait_cnt_d;
    logic                    timeout_q,    timeout_d;

    logic                    arb_valid;
    port_e                   arb_port;
    req_t                    sel_req;
    logic                    timeout_hit;
    logic                    rsp_done;
    logic [DATA_WIDTH-1:0]   rsp_data;

    rr_arbiter_2 #(
        .FIXED_PRIORITY (FIXED_PRIORITY)
    ) u_arb (
        .clock       (clock),
        .reset       (reset),
        .grant_en    (state_q == IDLE),
        .req_instr   (i_pending_q),
        .req_data    (d_pending_q),
        .grant_valid (arb_valid),
        .grant_port  (arb_port)
    );

    assign sel_req     = (arb_port == PORT_DATA) ? d_req_q : i_req_q;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Request capture, IDLE/ISSUE/WAIT sequencing, watchdog and response steering.
    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that
        // skipped an assignment would otherwise infer a latch.
        state_d      = state_q;
        grant_d      = grant_q;
        i_req_d      = i_req_q;
        d_req_d      = d_req_q;
        i_pending_d  = i_pending_q;
        d_pending_d  = d_pending_q;
        i_valid_d    = 1'b0;
        d_valid_d    = 1'b0;
        i_data_d     = i_data_q;
        d_data_d     = d_data_q;
        i_addr_out_d = i_addr_out_q;
        d_addr_out_d = d_addr_out_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        wait_cnt_d   = wait_cnt_q;
        timeout_d    = timeout_q;
        rsp_done     = 1'b0;
        rsp_data     = '0;

        // Capture into an empty request register; ready is registered, so
        // acceptance never feeds back combinationally into ready.
        if (i_mem_read && i_ready_q) begin
            i_req_d.op      = OP_READ;
            i_req_d.byte_en = '0;
            i_req_d.addr    = i_mem_address_in;
            i_req_d.data    = '0;
            i_pending_d     = 1'b1;
        end
        if ((d_mem_read || d_mem_write) && d_ready_q) begin
            d_req_d.op      = d_mem_write ? OP_WRITE : OP_READ;
            d_req_d.byte_en = d_mem_byte_en;
            d_req_d.addr    = d_mem_address_in;
            d_req_d.data    = d_mem_data_in;
            d_pending_d     = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d     = arb_port;
                    state_d     = ISSUE;
                    mem_read_d  = (sel_req.op == OP_READ);
                    mem_write_d = (sel_req.op == OP_WRITE);
                    mem_addr_d  = sel_req.addr;
                    mem_be_d    = (sel_req.op == OP_WRITE) ? sel_req.byte_en : '0;
                    mem_wdata_d = (sel_req.op == OP_WRITE) ? sel_req.data : '0;
                end
            end
            ISSUE: begin
                if (mem.mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    mem_be_d    = '0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    wait_cnt_d  = '0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (mem.mem_valid) begin
                    rsp_done = 1'b1;
                    rsp_data = mem.mem_data_out;
                end else if (timeout_hit) begin
                    rsp_done  = 1'b1;
                    rsp_data  = '0;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Response goes to whichever port owns the outstanding transaction.
        if (rsp_done) begin
            state_d = IDLE;
            if (grant_q == PORT_DATA) begin
                d_valid_d    = 1'b1;
                d_data_d     = rsp_data;
                d_addr_out_d = d_req_q.addr;
                d_pending_d  = 1'b0;
            end else begin
                i_valid_d    = 1'b1;
                i_data_d     = rsp_data;
                i_addr_out_d = i_req_q.addr;
                i_pending_d  = 1'b0;
            end
        end

        i_ready_d = !i_pending_d;
        d_ready_d = !d_pending_d;
    end

    // All state and registered outputs; reset discards any transaction in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= PORT_INSTR;
            i_req_q      <= '0;
            d_req_q      <= '0;
            i_pending_q  <= 1'b0;
            d_pending_q  <= 1'b0;
            i_ready_q    <= 1'b1;
            d_ready_q    <= 1'b1;
            i_valid_q    <= 1'b0;
            d_valid_q    <= 1'b0;
            i_data_q     <= '0;
            d_data_q     <= '0;
            i_addr_out_q <= '0;
            d_addr_out_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            wait_cnt_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q      <= state_d;
            grant_q      <= grant_d;
            i_req_q      <= i_req_d;
            d_req_q      <= d_req_d;
            i_pending_q  <= i_pending_d;
            d_pending_q  <= d_pending_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
            i_valid_q    <= i_valid_d;
            d_valid_q    <= d_valid_d;
            i_data_q     <= i_data_d;
            d_data_q     <= d_data_d;
            i_addr_out_q <= i_addr_out_d;
            d_addr_out_q <= d_addr_out_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            wait_cnt_q   <= wait_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    assign i_mem_ready       = i_ready_q;
    assign i_mem_valid       = i_valid_q;
    assign i_mem_data_out    = i_data_q;
    assign i_mem_address_out = i_addr_out_q;
    assign d_mem_ready       = d_ready_q;
    assign d_mem_valid       = d_valid_q;
    assign d_mem_data_out    = d_data_q;
    assign d_mem_address_out = d_addr_out_q;
    assign mem.mem_read       = mem_read_q;
    assign mem.mem_write      = mem_write_q;
    assign mem.mem_byte_en    = mem_be_q;
    assign mem.mem_address_in = mem_addr_q;
    assign mem.mem_data_in    = mem_wdata_q;
    assign timeout_error     = timeout_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter driven by the
// same stimulus, both with an 8-cycle watchdog. Inputs change 1 time unit
// after each rising edge; outputs are checked at that point.
module tb_memory_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_read = 1'b0;
    logic [31:0] i_addr = '0;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        mem_ready = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        i_ready_rr, i_valid_rr, d_ready_rr, d_valid_rr, timeout_rr;
    logic [31:0] i_data_rr, i_aout_rr, d_data_rr, d_aout_rr;
    logic        i_ready_fp, i_valid_fp, d_ready_fp, d_valid_fp, timeout_fp;
    logic [31:0] i_data_fp, i_aout_fp, d_data_fp, d_aout_fp;

    int n_checks = 0;
    int n_fails  = 0;

    memory_port_arbiter_if #(.DATA_WIDTH(32), .ADDRESS_BITS(32)) mif_rr ();
    memory_port_arbiter_if #(.DATA_WIDTH(32), .ADDRESS_BITS(32)) mif_fp ();

    assign mif_rr.mem_ready    = mem_ready;
    assign mif_rr.mem_valid    = mem_valid;
    assign mif_rr.mem_data_out = mem_rdata;
    assign mif_fp.mem_ready    = mem_ready;
    assign mif_fp.mem_valid    = mem_valid;
    assign mif_fp.mem_data_out = mem_rdata;

    memory_port_arbiter #(
        .DATA_WIDTH(32), .ADDRESS_BITS(32), .FIXED_PRIORITY(0), .TIMEOUT_CYCLES(8)
    ) dut_rr (
        .clock(clock), .reset(reset),
        .i_mem_read(i_read), .i_mem_address_in(i_addr),
        .i_mem_ready(i_ready_rr), .i_mem_valid(i_valid_rr),
        .i_mem_data_out(i_data_rr), .i_mem_address_out(i_aout_rr),
        .d_mem_read(d_read), .d_mem_write(d_write), .d_mem_byte_en(d_be),
        .d_mem_address_in(d_addr), .d_mem_data_in(d_wdata),
        .d_mem_ready(d_ready_rr), .d_mem_valid(d_valid_rr),
        .d_mem_data_out(d_data_rr), .d_mem_address_out(d_aout_rr),
        .mem(mif_rr),
        .timeout_error(timeout_rr)
    );

    memory_port_arbiter #(
        .DATA_WIDTH(32), .ADDRESS_BITS(32), .FIXED_PRIORITY(1), .TIMEOUT_CYCLES(8)
    ) dut_fp (
        .clock(clock), .reset(reset),
        .i_mem_read(i_read), .i_mem_address_in(i_addr),
        .i_mem_ready(i_ready_fp), .i_mem_valid(i_valid_fp),
        .i_mem_data_out(i_data_fp), .i_mem_address_out(i_aout_fp),
        .d_mem_read(d_read), .d_mem_write(d_write), .d_mem_byte_en(d_be),
        .d_mem_address_in(d_addr), .d_mem_data_in(d_wdata),
        .d_mem_ready(d_ready_fp), .d_mem_valid(d_valid_fp),
        .d_mem_data_out(d_data_fp), .d_mem_address_out(d_aout_fp),
        .mem(mif_fp),
        .timeout_error(timeout_fp)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // ---------------- reset values ----------------
        #12;
        check("rst i_ready",   i_ready_rr, 1);
        check("rst d_ready",   d_ready_rr, 1);
        check("rst i_valid",   i_valid_rr, 0);
        check("rst d_valid",   d_valid_rr, 0);
        check("rst mem_read",  mif_rr.mem_read, 0);
        check("rst mem_write", mif_rr.mem_write, 0);
        check("rst mem_addr",  mif_rr.mem_address_in, 0);
        check("rst timeout",   timeout_rr, 0);
        check("rst d_data",    d_data_rr, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        mem_ready = 1'b1;
        tick();

        // ---------------- first tie after reset ----------------
        i_read = 1'b1; i_addr = 32'h80;
        d_read = 1'b1; d_addr = 32'h200;
        tick();                                                   // cycle 1
        check("tie1 i_ready low", i_ready_rr, 0);
        check("tie1 d_ready low", d_ready_rr, 0);
        check("tie1 idle no cmd", mif_rr.mem_read, 0);
        i_read = 1'b0; d_read = 1'b0;
        tick();                                                   // cycle 2
        check("tie1 rr cmd",  mif_rr.mem_read, 1);
        check("tie1 rr addr", mif_rr.mem_address_in, 32'h80);
        check("tie1 fp addr", mif_fp.mem_address_in, 32'h200);
        tick();                                                   // cycle 3
        check("tie1 wait no cmd", mif_rr.mem_read, 0);
        mem_valid = 1'b1; mem_rdata = 32'h1111_1111;
        tick();                                                   // cycle 4
        mem_valid = 1'b0;
        check("tie1 rr i_valid", i_valid_rr, 1);
        check("tie1 rr i_data",  i_data_rr, 32'h1111_1111);
        check("tie1 rr d_valid", d_valid_rr, 0);
        check("tie1 rr i_ready", i_ready_rr, 1);
        check("tie1 fp d_valid", d_valid_fp, 1);
        check("tie1 fp d_aout",  d_aout_fp, 32'h200);
        check("tie1 fp i_valid", i_valid_fp, 0);
        tick();                                                   // cycle 5
        check("tie1 rr 2nd addr",  mif_rr.mem_address_in, 32'h200);
        check("tie1 fp 2nd addr",  mif_fp.mem_address_in, 32'h80);
        check("tie1 rr i_valid 0", i_valid_rr, 0);
        tick();                                                   // cycle 6
        mem_valid = 1'b1; mem_rdata = 32'h2222_2222;
        tick();                                                   // cycle 7
        mem_valid = 1'b0;
        check("tie1 rr d_valid 2nd", d_valid_rr, 1);
        check("tie1 rr d_data",      d_data_rr, 32'h2222_2222);
        check("tie1 rr d_aout",      d_aout_rr, 32'h200);
        check("tie1 fp i_valid 2nd", i_valid_fp, 1);
        check("tie1 fp i_aout",      i_aout_fp, 32'h80);
        tick();

        // ---------------- lone instruction read ----------------
        i_read = 1'b1; i_addr = 32'h40;
        tick();                                                   // cycle 1
        i_read = 1'b0;
        check("lone i_ready low", i_ready_rr, 0);
        tick();                                                   // cycle 2
        check("lone mem_read",  mif_rr.mem_read, 1);
        check("lone mem_write", mif_rr.mem_write, 0);
        check("lone addr",      mif_rr.mem_address_in, 32'h40);
        check("lone be zero",   mif_rr.mem_byte_en, 0);
        check("lone wdata zero", mif_rr.mem_data_in, 0);
        tick();                                                   // cycle 3
        check("lone wait no cmd", mif_rr.mem_read, 0);
        mem_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();                                                   // cycle 4
        mem_valid = 1'b0;
        check("lone i_valid", i_valid_rr, 1);
        check("lone i_data",  i_data_rr, 32'hDEAD_BEEF);
        check("lone i_aout",  i_aout_rr, 32'h40);
        check("lone i_ready", i_ready_rr, 1);
        check("lone d_valid", d_valid_rr, 0);
        tick();                                                   // cycle 5
        check("lone i_valid pulse", i_valid_rr, 0);

        // ---------------- repeat tie: last grant was instruction ----------------
        i_read = 1'b1; i_addr = 32'h84;
        d_read = 1'b1; d_addr = 32'h204;
        tick();
        i_read = 1'b0; d_read = 1'b0;
        tick();                                                   // cycle 2
        check("tie2 rr data first", mif_rr.mem_address_in, 32'h204);
        check("tie2 fp data first", mif_fp.mem_address_in, 32'h204);
        tick();
        mem_valid = 1'b1; mem_rdata = 32'h3333_3333;
        tick();                                                   // cycle 4
        mem_valid = 1'b0;
        check("tie2 rr d_valid", d_valid_rr, 1);
        check("tie2 rr d_data",  d_data_rr, 32'h3333_3333);
        check("tie2 rr i_valid", i_valid_rr, 0);
        check("tie2 fp d_valid", d_valid_fp, 1);
        tick();                                                   // cycle 5
        check("tie2 rr instr next", mif_rr.mem_address_in, 32'h84);
        tick();
        mem_valid = 1'b1; mem_rdata = 32'h4444_4444;
        tick();                                                   // cycle 7
        mem_valid = 1'b0;
        check("tie2 rr i_valid", i_valid_rr, 1);
        check("tie2 rr i_aout",  i_aout_rr, 32'h84);
        check("tie2 rr i_data",  i_data_rr, 32'h4444_4444);
        tick();

        // ---------------- data write with stalled memory ----------------
        mem_ready = 1'b0;
        d_read = 1'b1; d_write = 1'b1; d_be = 4'b0011;
        d_addr = 32'h100; d_wdata = 32'h1234_5678;
        tick();                                                   // cycle 1
        d_read = 1'b0; d_write = 1'b0;
        check("wr d_ready low", d_ready_rr, 0);
        tick();                                                   // cycle 2
        for (int k = 0; k < 4; k++) begin
            if (k == 3) mem_ready = 1'b1;
            check($sformatf("wr hold%0d write", k), mif_rr.mem_write, 1);
            check($sformatf("wr hold%0d read", k),  mif_rr.mem_read, 0);
            check($sformatf("wr hold%0d addr", k),  mif_rr.mem_address_in, 32'h100);
            check($sformatf("wr hold%0d data", k),  mif_rr.mem_data_in, 32'h1234_5678);
            check($sformatf("wr hold%0d be", k),    mif_rr.mem_byte_en, 32'h3);
            tick();
        end
        check("wr wait no cmd", mif_rr.mem_write, 0);            // cycle 6
        mem_valid = 1'b1; mem_rdata = 32'hA5A5_A5A5;
        tick();                                                   // cycle 7
        mem_valid = 1'b0;
        check("wr d_valid", d_valid_rr, 1);
        check("wr d_aout",  d_aout_rr, 32'h100);
        check("wr d_data",  d_data_rr, 32'hA5A5_A5A5);
        check("wr d_ready", d_ready_rr, 1);
        check("wr i_valid", i_valid_rr, 0);
        tick();                                                   // cycle 8
        check("wr d_valid pulse", d_valid_rr, 0);

        // ---------------- watchdog: memory never responds ----------------
        i_read = 1'b1; i_addr = 32'h300;
        tick();
        i_read = 1'b0;
        tick();                                                   // cycle 2 ISSUE
        tick();                                                   // cycle 3 first WAIT
        mem_rdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 7; k++) tick();                       // cycle 10, 8th WAIT
        check("to 8th wait i_valid", i_valid_rr, 0);
        check("to 8th wait flag",    timeout_rr, 0);
        tick();                                                   // cycle 11
        check("to i_valid",   i_valid_rr, 1);
        check("to i_data",    i_data_rr, 0);
        check("to i_aout",    i_aout_rr, 32'h300);
        check("to flag",      timeout_rr, 1);
        check("to i_ready",   i_ready_rr, 1);
        check("to fp flag",   timeout_fp, 1);
        check("to fp i_data", i_data_fp, 0);
        tick();
        mem_valid = 1'b1; mem_rdata = 32'h5555_5555;
        tick();
        mem_valid = 1'b0;
        check("late rsp i_valid", i_valid_rr, 0);
        check("late rsp d_valid", d_valid_rr, 0);
        check("late rsp sticky",  timeout_rr, 1);
        tick();
        check("late rsp i_valid+1", i_valid_rr, 0);
        check("late rsp i_data",    i_data_rr, 0);

        // ---------------- reset during WAIT ----------------
        d_read = 1'b1; d_addr = 32'h500;
        tick();
        d_read = 1'b0;
        tick();                                                   // cycle 2 ISSUE
        check("rw issue", mif_rr.mem_read, 1);
        tick();                                                   // cycle 3 WAIT
        check("rw d_ready low", d_ready_rr, 0);
        reset = 1'b0;
        #1;
        check("rw async d_ready", d_ready_rr, 1);
        check("rw async i_ready", i_ready_rr, 1);
        check("rw async timeout", timeout_rr, 0);
        check("rw async d_data",  d_data_rr, 0);
        check("rw async i_aout",  i_aout_rr, 0);
        mem_valid = 1'b1; mem_rdata = 32'h6666_6666;
        tick();
        reset = 1'b1;
        tick();
        mem_valid = 1'b0;
        check("rw no d_valid", d_valid_rr, 0);
        check("rw no i_valid", i_valid_rr, 0);
        tick();
        check("rw no d_valid+1", d_valid_rr, 0);
        check("rw d_ready",      d_ready_rr, 1);
        check("rw no cmd",       mif_rr.mem_read, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: bench time limit reached");
        $fatal(1, "bench time limit");
    end

endmodule
